// File: rtl/stage1.sv
// First CPU-side cache stage: 2-way, 8-set, 4-byte-line byte cache with LRU replacement.
// Misses allocate a zero-filled line. Evicted lines are dropped, and dirty bits are only recorded.
module stage1 (
  input  logic       clock,
  input  logic       reset_n,
  inout  logic [7:0] data_cpu,
  input  logic [8:0] addr_cpu,
  input  logic       rd_cpu,
  input  logic       wr_cpu
);

  logic [7:0]       data_q [2][8][4];
  logic [3:0]       tag_q  [2][8];
  logic [1:0][7:0]  valid_q;
  logic [1:0][7:0]  dirty_q;
  logic [7:0]       lru_q;
  logic [7:0]       rd_data_q;

  logic [3:0] tag;
  logic [2:0] idx;
  logic [1:0] off;
  logic       access;
  logic       rd_only;
  logic       hit0;
  logic       hit1;
  logic       hit;
  logic       way;
  logic [7:0] wr_byte;

  assign tag     = addr_cpu[8:5];
  assign idx     = addr_cpu[4:2];
  assign off     = addr_cpu[1:0];
  assign access  = wr_cpu | rd_cpu;
  assign rd_only = rd_cpu & ~wr_cpu;
  assign wr_byte = data_cpu;

  always_comb begin
    hit0 = valid_q[0][idx] && (tag_q[0][idx] == tag);
    hit1 = valid_q[1][idx] && (tag_q[1][idx] == tag);
    hit  = hit0 | hit1;
    way  = 1'b0;
    if (hit) begin
      way = hit1;
    end else if (!valid_q[0][idx]) begin
      way = 1'b0;
    end else if (!valid_q[1][idx]) begin
      way = 1'b1;
    end else begin
      way = lru_q[idx];
    end
  end

  // Line storage is not reset; valid bits alone decide what is live.
  always_ff @(posedge clock) begin
    if (access && !hit) begin
      tag_q[way][idx] <= tag;
      for (int b = 0; b < 4; b++) begin
        data_q[way][idx][b] <= (wr_cpu && (2'(b) == off)) ? wr_byte : 8'h00;
      end
    end else if (wr_cpu) begin
      data_q[way][idx][off] <= wr_byte;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= '0;
      dirty_q   <= '0;
      lru_q     <= '0;
      rd_data_q <= 8'h00;
    end else if (access) begin
      valid_q[way][idx] <= 1'b1;
      lru_q[idx]        <= ~way;
      if (wr_cpu) begin
        dirty_q[way][idx] <= 1'b1;
      end else if (!hit) begin
        dirty_q[way][idx] <= 1'b0;
      end
      if (rd_only) begin
        rd_data_q <= hit ? data_q[way][idx][off] : 8'h00;
      end
    end
  end

  assign data_cpu = rd_only ? rd_data_q : 8'bz;

endmodule

// File: tb/tb_stage1.sv
// Self-checking bench for stage1: directed scenarios plus randomized traffic
// compared against a set/way cache model.
module tb_stage1;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  wire  [7:0] data_cpu;
  logic [8:0] addr_cpu = '0;
  logic       rd_cpu = 1'b0;
  logic       wr_cpu = 1'b0;
  logic [7:0] drv_data = '0;
  logic       drv_en = 1'b0;

  assign data_cpu = drv_en ? drv_data : 8'bz;

  stage1 dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .data_cpu (data_cpu),
    .addr_cpu (addr_cpu),
    .rd_cpu   (rd_cpu),
    .wr_cpu   (wr_cpu)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Reference cache contents.
  bit         m_valid [2][8];
  bit         m_dirty [2][8];
  bit         m_lru   [8];
  logic [3:0] m_tag   [2][8];
  logic [7:0] m_data  [2][8][4];

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        m_valid[w][s] = 1'b0;
        m_dirty[w][s] = 1'b0;
      end
    for (int s = 0; s < 8; s++) m_lru[s] = 1'b0;
  endtask

  // One access by the cache rules; rv is the byte a read returns.
  task automatic model_access(input bit wr, input bit rd, input logic [8:0] a,
                              input logic [7:0] d, output logic [7:0] rv);
    int t, s, o, w;
    bit found;
    t = int'(a[8:5]);
    s = int'(a[4:2]);
    o = int'(a[1:0]);
    rv = 8'h00;
    if (!wr && !rd) return;
    found = 1'b0;
    w = 0;
    for (int i = 0; i < 2; i++)
      if (m_valid[i][s] && int'(m_tag[i][s]) == t) begin
        found = 1'b1;
        w = i;
      end
    if (!found) begin
      if (!m_valid[0][s]) w = 0;
      else if (!m_valid[1][s]) w = 1;
      else w = int'(m_lru[s]);
      m_valid[w][s] = 1'b1;
      m_tag[w][s] = 4'(t);
      m_dirty[w][s] = 1'b0;
      for (int b = 0; b < 4; b++) m_data[w][s][b] = 8'h00;
    end
    if (wr) begin
      m_data[w][s][o] = d;
      m_dirty[w][s] = 1'b1;
    end else begin
      rv = m_data[w][s][o];
    end
    m_lru[s] = (w == 0);
  endtask

  task automatic do_access(input bit wr, input bit rd, input logic [8:0] a,
                           input logic [7:0] d, input string tag);
    logic [7:0] exp;
    @(negedge clock);
    addr_cpu = a;
    wr_cpu = wr;
    rd_cpu = rd;
    drv_data = d;
    drv_en = wr;
    @(posedge clock);
    model_access(wr, rd, a, d, exp);
    #1;
    if (rd && !wr) check_eq(tag, data_cpu, exp);
    else if (wr) check_eq({tag, "_bus"}, data_cpu, d);
    @(negedge clock);
    wr_cpu = 1'b0;
    rd_cpu = 1'b0;
    drv_en = 1'b0;
  endtask

  // Reset pulse landing between edges, with a read request raised during it.
  task automatic mid_reset(input logic [8:0] a);
    @(posedge clock);
    #2;
    addr_cpu = a;
    rd_cpu = 1'b1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_bus", data_cpu, 8'h00);
    #1;
    reset_n = 1'b1;
    rd_cpu = 1'b0;
  endtask

  task automatic check_state();
    for (int w = 0; w < 2; w++)
      for (int s = 0; s < 8; s++) begin
        check_eq($sformatf("valid_w%0d_s%0d", w, s), 8'(dut.valid_q[w][s]), 8'(m_valid[w][s]));
        check_eq($sformatf("dirty_w%0d_s%0d", w, s), 8'(dut.dirty_q[w][s]), 8'(m_dirty[w][s]));
      end
    for (int s = 0; s < 8; s++)
      check_eq($sformatf("lru_s%0d", s), 8'(dut.lru_q[s]), 8'(m_lru[s]));
  endtask

  initial begin
    logic [7:0] dummy;
    logic [8:0] a;
    int kind;
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    check_state();

    // Held write repeats every edge and stays idempotent.
    @(negedge clock);
    addr_cpu = 9'h007;
    drv_data = 8'h66;
    drv_en = 1'b1;
    wr_cpu = 1'b1;
    repeat (12) begin
      @(posedge clock);
      model_access(1'b1, 1'b0, 9'h007, 8'h66, dummy);
    end
    #1;
    check_eq("hold_wr_bus", data_cpu, 8'h66);
    @(negedge clock);
    wr_cpu = 1'b0;
    drv_en = 1'b0;
    do_access(1'b0, 1'b1, 9'h007, 8'h00, "hold_rd");
    check_eq("hold_valid", 8'(dut.valid_q[0][1]), 8'h01);
    check_eq("hold_dirty", 8'(dut.dirty_q[0][1]), 8'h01);

    // Read miss allocates a clean zero line, then hits.
    mid_reset(9'h000);
    do_access(1'b0, 1'b1, 9'h003, 8'h00, "rdmiss");
    check_eq("rdmiss_valid", 8'(dut.valid_q[0][0]), 8'h01);
    check_eq("rdmiss_dirty", 8'(dut.dirty_q[0][0]), 8'h00);
    do_access(1'b0, 1'b1, 9'h003, 8'h00, "rdhit");

    // Two tags in one set, then an eviction.
    mid_reset(9'h000);
    do_access(1'b1, 1'b0, 9'h007, 8'h11, "wr007");
    do_access(1'b1, 1'b0, 9'h027, 8'h22, "wr027");
    do_access(1'b0, 1'b1, 9'h007, 8'h00, "rd007");
    do_access(1'b0, 1'b1, 9'h027, 8'h00, "rd027");
    do_access(1'b1, 1'b0, 9'h047, 8'h33, "wr047");
    do_access(1'b0, 1'b1, 9'h047, 8'h00, "rd047");
    do_access(1'b0, 1'b1, 9'h027, 8'h00, "rd027b");
    do_access(1'b0, 1'b1, 9'h007, 8'h00, "rd007_evicted");

    // Both requests high: write wins, bus released.
    do_access(1'b1, 1'b1, 9'h010, 8'hA5, "both");
    do_access(1'b0, 1'b1, 9'h010, 8'h00, "rd010");

    // Reset mid-operation invalidates everything.
    do_access(1'b1, 1'b0, 9'h027, 8'h22, "wr027_pre");
    mid_reset(9'h027);
    do_access(1'b0, 1'b1, 9'h027, 8'h00, "rd027_post");
    check_state();

    // Randomized traffic over a few tags and sets to force conflicts.
    for (int i = 0; i < 400; i++) begin
      a = {2'b00, 2'($urandom_range(0, 3)), 1'b0, 2'($urandom_range(0, 3)),
           2'($urandom_range(0, 3))};
      kind = $urandom_range(0, 9);
      if (i % 97 == 96) mid_reset(a);
      else if (kind < 4) do_access(1'b1, 1'b0, a, 8'($urandom), "rnd_wr");
      else if (kind < 8) do_access(1'b0, 1'b1, a, 8'h00, "rnd_rd");
      else if (kind < 9) do_access(1'b1, 1'b1, a, 8'($urandom), "rnd_both");
      else do_access(1'b0, 1'b0, a, 8'h00, "rnd_idle");
    end
    check_state();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
